// File: rtl/cpu_bus_fabric_if.sv
// CPU-facing and device-facing signal bundles for cpu_bus_fabric.
// On each bus the master modport is the side that issues requests.
interface cpu_bus_fabric_cpu_if;
  logic        cpu_request;
  logic        cpu_ack;
  logic        cpu_error;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        err_valid;
  logic [31:0] err_address;
  logic        err_timeout;
  logic        err_clear;

  modport master (
    output cpu_request, cpu_wmask, cpu_address, cpu_wdata, err_clear,
    input  cpu_ack, cpu_error, cpu_rdata, err_valid, err_address, err_timeout
  );
  modport slave (
    input  cpu_request, cpu_wmask, cpu_address, cpu_wdata, err_clear,
    output cpu_ack, cpu_error, cpu_rdata, err_valid, err_address, err_timeout
  );
endinterface

interface cpu_bus_fabric_dev_if #(
  parameter int NUM_DEVICES = 8
);
  logic [NUM_DEVICES-1:0]    dev_request;
  logic [NUM_DEVICES-1:0]    dev_ack;
  logic [3:0]                dev_wmask;
  logic [31:0]               dev_address;
  logic [31:0]               dev_wdata;
  logic [32*NUM_DEVICES-1:0] dev_rdata;

  modport master (
    output dev_request, dev_wmask, dev_address, dev_wdata,
    input  dev_ack, dev_rdata
  );
  modport slave (
    input  dev_request, dev_wmask, dev_address, dev_wdata,
    output dev_ack, dev_rdata
  );
endinterface

// File: rtl/cpu_bus_fabric.sv
// Single-outstanding CPU bus interconnect: address decode, registered device
// request, unmapped/timeout error responses and a sticky first-fault register.
//
// state | meaning
// IDLE  | waiting for cpu_request; latch request and decode target
// WAIT  | dev_request held toward target; watchdog counting down
// RESP  | cpu_ack pulse (with cpu_error on unmapped/timeout)
// DONE  | CPU is dropping its request; cpu_request ignored
module cpu_bus_fabric #(
  parameter int          NUM_DEVICES    = 8,
  parameter int          DECODE_MSB     = 31,
  parameter int          DECODE_LSB     = 28,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERROR_RDATA    = 32'hDEAD_BEEF
) (
  input logic                  clk,
  input logic                  reset_n,
  cpu_bus_fabric_cpu_if.slave  cpu,
  cpu_bus_fabric_dev_if.master dev
);

  localparam int SEL_W = DECODE_MSB - DECODE_LSB + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_DEVICES-1:0] dev_request_q;
  logic [3:0]             dev_wmask_q;
  logic [31:0]            dev_address_q;
  logic [31:0]            dev_wdata_q;
  logic                   cpu_ack_q;
  logic                   cpu_error_q;
  logic [31:0]            cpu_rdata_q;
  logic                   err_valid_q;
  logic [31:0]            err_address_q;
  logic                   err_timeout_q;

  logic [SEL_W-1:0] sel;
  logic             mapped;
  logic             ack_hit;
  logic             err_load;
  logic [31:0]      rdata_sel;

  assign sel      = cpu.cpu_address[DECODE_MSB:DECODE_LSB];
  assign mapped   = (32'(sel) < 32'(NUM_DEVICES));
  // dev_request_q is one-hot on the target, so it doubles as the ack/rdata select
  assign ack_hit  = |(dev.dev_ack & dev_request_q);
  assign err_load = !err_valid_q || cpu.err_clear;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (dev_request_q[i]) rdata_sel = rdata_sel | dev.dev_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dev_request_q <= '0;
      dev_wmask_q   <= '0;
      dev_address_q <= '0;
      dev_wdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_error_q   <= 1'b0;
      cpu_rdata_q   <= '0;
      err_valid_q   <= 1'b0;
      err_address_q <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cpu_ack_q   <= 1'b0;
      cpu_error_q <= 1'b0;
      // a capture later in this block overrides the clear
      if (cpu.err_clear) err_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu.cpu_request) begin
            dev_wmask_q   <= cpu.cpu_wmask;
            dev_address_q <= cpu.cpu_address;
            dev_wdata_q   <= cpu.cpu_wdata;
            if (mapped) begin
              dev_request_q <= NUM_DEVICES'(1) << sel;
              cnt_q         <= CNT_W'(TIMEOUT_CYCLES - 1);
              state_q       <= WAIT;
            end else begin
              cpu_ack_q   <= 1'b1;
              cpu_error_q <= 1'b1;
              cpu_rdata_q <= ERROR_RDATA;
              if (err_load) begin
                err_valid_q   <= 1'b1;
                err_address_q <= cpu.cpu_address;
                err_timeout_q <= 1'b0;
              end
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (ack_hit) begin
            dev_request_q <= '0;
            cpu_ack_q     <= 1'b1;
            cpu_rdata_q   <= rdata_sel;
            state_q       <= RESP;
          end else if (cnt_q == '0) begin
            dev_request_q <= '0;
            cpu_ack_q     <= 1'b1;
            cpu_error_q   <= 1'b1;
            cpu_rdata_q   <= ERROR_RDATA;
            if (err_load) begin
              err_valid_q   <= 1'b1;
              err_address_q <= dev_address_q;
              err_timeout_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP:    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu.cpu_ack     = cpu_ack_q;
  assign cpu.cpu_error   = cpu_error_q;
  assign cpu.cpu_rdata   = cpu_rdata_q;
  assign cpu.err_valid   = err_valid_q;
  assign cpu.err_address = err_address_q;
  assign cpu.err_timeout = err_timeout_q;

  assign dev.dev_request = dev_request_q;
  assign dev.dev_wmask   = dev_wmask_q;
  assign dev.dev_address = dev_address_q;
  assign dev.dev_wdata   = dev_wdata_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Bench for cpu_bus_fabric: directed scenarios plus randomized transactions
// checked against a cycle-level transaction model of the bus protocol.
module tb_cpu_bus_fabric;

  localparam int          ND   = 8;
  localparam int          DMSB = 31;
  localparam int          DLSB = 28;
  localparam int          TO   = 16;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  bit          m_ev;
  logic [31:0] m_ea;
  bit          m_et;

  cpu_bus_fabric_cpu_if                     cpu_if ();
  cpu_bus_fabric_dev_if #(.NUM_DEVICES(ND)) dev_if ();

  cpu_bus_fabric #(
    .NUM_DEVICES(ND), .DECODE_MSB(DMSB), .DECODE_LSB(DLSB),
    .TIMEOUT_CYCLES(TO), .ERROR_RDATA(ERR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu(cpu_if.slave), .dev(dev_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Error-register model: one clock edge worth of capture/clear behaviour.
  task automatic model_edge(input bit cap_now, input bit clr_now,
                            input logic [31:0] addr, input bit tmo);
    if (cap_now && (!m_ev || clr_now)) begin
      m_ev = 1'b1;
      m_ea = addr;
      m_et = tmo;
    end else if (clr_now) begin
      m_ev = 1'b0;
    end
  endtask

  // One CPU transaction. ack_cyc: cycle the target acks (0 = never, > TO is late).
  task automatic drive_txn(input logic [31:0] addr, input logic [3:0] wmask,
                           input logic [31:0] wdata, input int ack_cyc,
                           input logic [31:0] rd, input int clr_cyc,
                           input int noise_dev);
    int              sel, resp, req_end, cap;
    bit              mapped, err;
    logic [ND-1:0]   oh, exp_req;
    logic [31:0]     exp_rd;
    sel     = int'(addr[DMSB:DLSB]);
    mapped  = (sel < ND);
    oh      = mapped ? (ND'(1) << sel) : '0;
    cap     = -1;
    req_end = 0;
    if (!mapped) begin
      resp = 1; err = 1'b1; cap = 0;
    end else if (ack_cyc >= 1 && ack_cyc <= TO) begin
      resp = ack_cyc + 1; err = 1'b0; req_end = ack_cyc;
    end else begin
      resp = TO + 1; err = 1'b1; cap = TO; req_end = TO;
    end
    exp_rd = err ? ERR : rd;

    @(negedge clk);
    cpu_if.cpu_request = 1'b1;
    cpu_if.cpu_address = addr;
    cpu_if.cpu_wdata   = wdata;
    cpu_if.cpu_wmask   = wmask;
    cpu_if.err_clear   = (clr_cyc == 0);
    dev_if.dev_ack     = '0;
    @(posedge clk);
    model_edge(cap == 0, clr_cyc == 0, addr, mapped);

    for (int c = 1; c <= resp + 3; c++) begin
      @(negedge clk);
      exp_req = (mapped && c <= req_end) ? oh : '0;
      n_vec++;
      if (dev_if.dev_request !== exp_req) begin
        n_err++;
        $display("FAIL dev_request c=%0d addr=%h: got %b expected %b", c, addr, dev_if.dev_request, exp_req);
      end
      n_vec++;
      if (cpu_if.cpu_ack !== (c == resp)) begin
        n_err++;
        $display("FAIL cpu_ack c=%0d addr=%h: got %b expected %b", c, addr, cpu_if.cpu_ack, (c == resp));
      end
      n_vec++;
      if (cpu_if.cpu_error !== (c == resp && err)) begin
        n_err++;
        $display("FAIL cpu_error c=%0d addr=%h: got %b expected %b", c, addr, cpu_if.cpu_error, (c == resp && err));
      end
      if (c == resp) begin
        n_vec++;
        if (cpu_if.cpu_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL cpu_rdata addr=%h: got %h expected %h", addr, cpu_if.cpu_rdata, exp_rd);
        end
      end
      if (c == 1) begin
        n_vec++;
        if ({dev_if.dev_address, dev_if.dev_wdata, dev_if.dev_wmask} !== {addr, wdata, wmask}) begin
          n_err++;
          $display("FAIL dev_latch: got %h/%h/%h expected %h/%h/%h", dev_if.dev_address,
                   dev_if.dev_wdata, dev_if.dev_wmask, addr, wdata, wmask);
        end
      end
      for (int i = 0; i < ND; i++) dev_if.dev_rdata[32*i +: 32] = $urandom;
      dev_if.dev_ack = '0;
      if (mapped && c == ack_cyc) begin
        dev_if.dev_ack = dev_if.dev_ack | (ND'(1) << sel);
        dev_if.dev_rdata[32*sel +: 32] = rd;
      end
      if (noise_dev >= 0) dev_if.dev_ack = dev_if.dev_ack | (ND'(1) << noise_dev);
      cpu_if.err_clear   = (c == clr_cyc);
      cpu_if.cpu_request = (c < resp);
      @(posedge clk);
      model_edge(c == cap, c == clr_cyc, addr, mapped);
    end
    #1;
    cpu_if.err_clear = 1'b0;
    dev_if.dev_ack   = '0;
    n_vec++;
    if ({cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout} !== {m_ev, m_ea, m_et}) begin
      n_err++;
      $display("FAIL err_regs addr=%h: got v=%b a=%h t=%b expected v=%b a=%h t=%b", addr,
               cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout, m_ev, m_ea, m_et);
    end
  endtask

  task automatic test_reset();
    reset_n            = 1'b0;
    cpu_if.cpu_request = 1'b0;
    cpu_if.cpu_address = '0;
    cpu_if.cpu_wdata   = '0;
    cpu_if.cpu_wmask   = '0;
    cpu_if.err_clear   = 1'b0;
    dev_if.dev_ack     = '0;
    dev_if.dev_rdata   = '0;
    m_ev = 1'b0; m_ea = '0; m_et = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({cpu_if.cpu_ack, cpu_if.cpu_error, cpu_if.cpu_rdata, dev_if.dev_request, dev_if.dev_wmask,
         dev_if.dev_address, dev_if.dev_wdata, cpu_if.err_valid, cpu_if.err_address,
         cpu_if.err_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got nonzero outputs, expected all zero");
    end
    reset_n = 1'b1;
  endtask

  task automatic test_read_dev2();
    drive_txn(32'h2000_0010, 4'h0, 32'h0, 3, 32'h1234_5678, -1, -1);
  endtask

  task automatic test_write_dev0();
    drive_txn(32'h0000_0100, 4'hF, 32'hA5A5_A5A5, 1, 32'h0BAD_0BAD, -1, 1);
  endtask

  task automatic test_unmapped();
    drive_txn(32'hF000_0000, 4'h0, 32'h0, 0, 32'h0, -1, -1);
    n_vec++;
    if ({cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout} !== {1'b1, 32'hF000_0000, 1'b0}) begin
      n_err++;
      $display("FAIL unmapped_capture: got v=%b a=%h t=%b expected v=1 a=f0000000 t=0",
               cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout);
    end
  endtask

  task automatic test_timeout();
    drive_txn(32'h5000_0000, 4'h3, 32'h1111_2222, 20, 32'h0, 0, -1);
    n_vec++;
    if ({cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout} !== {1'b1, 32'h5000_0000, 1'b1}) begin
      n_err++;
      $display("FAIL timeout_capture: got v=%b a=%h t=%b expected v=1 a=50000000 t=1",
               cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout);
    end
  endtask

  task automatic test_err_sticky();
    drive_txn(32'h9000_0000, 4'h0, 32'h0, 0, 32'h0, -1, -1);
    n_vec++;
    if (cpu_if.err_address !== 32'h5000_0000) begin
      n_err++;
      $display("FAIL sticky_hold: got %h expected 50000000", cpu_if.err_address);
    end
    drive_txn(32'hA000_0004, 4'h0, 32'h0, 0, 32'h0, 0, -1);
    n_vec++;
    if ({cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout} !== {1'b1, 32'hA000_0004, 1'b0}) begin
      n_err++;
      $display("FAIL clear_vs_capture: got v=%b a=%h t=%b expected v=1 a=a0000004 t=0",
               cpu_if.err_valid, cpu_if.err_address, cpu_if.err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_if.cpu_request = 1'b1;
    cpu_if.cpu_address = 32'h3000_0000;
    cpu_if.cpu_wdata   = 32'h7777_7777;
    cpu_if.cpu_wmask   = 4'h1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dev_if.dev_request !== 8'b0000_1000) begin
      n_err++;
      $display("FAIL wait_before_reset: got %b expected 00001000", dev_if.dev_request);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({cpu_if.cpu_ack, cpu_if.cpu_error, cpu_if.cpu_rdata, dev_if.dev_request, dev_if.dev_wmask,
         dev_if.dev_address, dev_if.dev_wdata, cpu_if.err_valid, cpu_if.err_address,
         cpu_if.err_timeout} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got nonzero outputs, expected all zero");
    end
    m_ev = 1'b0; m_ea = '0; m_et = 1'b0;
    @(negedge clk);
    cpu_if.cpu_request = 1'b0;
    reset_n = 1'b1;
    drive_txn(32'h3000_0040, 4'h0, 32'h0, 2, 32'hCAFE_F00D, -1, -1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          sel, ack_cyc, clr_cyc, noise;
    for (int n = 0; n < 40; n++) begin
      addr    = $urandom;
      sel     = int'(addr[DMSB:DLSB]);
      ack_cyc = $urandom_range(0, TO + 3);
      clr_cyc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TO + 2) : -1;
      noise   = -1;
      if ($urandom_range(0, 1) == 1) begin
        noise = $urandom_range(0, ND - 1);
        if (noise == sel) noise = (noise + 1) % ND;
      end
      drive_txn(addr, 4'($urandom), $urandom, ack_cyc, $urandom, clr_cyc, noise);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_read_dev2();
    test_write_dev0();
    test_unmapped();
    test_timeout();
    test_err_sticky();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
